// File: rtl/axis_block_serializer.sv
// Output stage of the AES datapath: buffers 128-bit result blocks in a small
// block FIFO and serializes each one into AXI4-Stream beats, MSB word first.
module axis_block_serializer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH          = 128,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic                                blk_valid,
    output logic                                blk_ready,
    input  logic [BLOCK_WIDTH-1:0]              blk_data,
    input  logic                                blk_last,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast
);

    localparam int TW    = C_M_AXIS_TDATA_WIDTH;
    localparam int BEATS = BLOCK_WIDTH / TW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int EW    = BLOCK_WIDTH + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [EW-1:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  beat_q, beat_d;
    // Held low through reset so blk_ready only rises on the first edge after release.
    logic           live_q, live_d;

    logic           push;
    logic           pop;
    logic           beat_hs;
    logic [EW-1:0]  head;
    logic [TW-1:0]  head_word;

    // Handshake rules: a block moves when blk_valid && blk_ready, a beat moves
    // when m00_axis_tvalid && m00_axis_tready; valid never waits on ready.
    always_comb begin
        blk_ready = live_q && (count_q != FULL_CNT);
        push      = blk_valid && blk_ready;
        head      = mem_q[rd_ptr_q];

        m00_axis_tvalid = (state_q == ST_SEND);
        beat_hs         = m00_axis_tvalid && m00_axis_tready;
        pop             = beat_hs && (beat_q == LAST_BEAT);

        head_word = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) begin
                head_word = head[BLOCK_WIDTH-1-i*TW -: TW];
            end
        end

        m00_axis_tdata = m00_axis_tvalid ? head_word : '0;
        m00_axis_tlast = m00_axis_tvalid && head[BLOCK_WIDTH] && (beat_q == LAST_BEAT);
        m00_axis_tstrb = '1;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        live_d   = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = {blk_last, blk_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (beat_hs) begin
            if (beat_q == LAST_BEAT) begin
                beat_d   = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pop && !push && (count_q == CW'(1))) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            live_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            live_q   <= live_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
